// File: rtl/sram_resp_pkg.sv
// Shared constants for the sram_resp slice: transfer-size encodings, LFSR seed,
// response age width and a byte-merge helper used on write handshakes.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Ages saturate well above the largest legal latency (4).
  localparam int AGE_W = 3;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// resp_fifo: in-order queue of outstanding responses {wr, rdata, age}.
// Every entry ages once per cycle; a freshly pushed entry starts at age 1.
module resp_fifo
  import sram_resp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              push_wr,
  input  logic [31:0]       push_data,
  input  logic              pop,
  output logic              head_wr,
  output logic [31:0]       head_data,
  output logic [AGE_W-1:0]  head_age,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic              wr_q   [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wr_q[i]   <= 1'b0;
        data_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + 1'b1;
      end
      // The push slot overrides the blanket ageing above.
      if (push) begin
        wr_q[wr_ptr]   <= push_wr;
        data_q[wr_ptr] <= push_data;
        age_q[wr_ptr]  <= AGE_W'(1);
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_wr   = wr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_age  = age_q[rd_ptr];

endmodule

// File: rtl/sram_resp.sv
// sram_resp: word SRAM behind a req/addr_ok + data_ok pipelined handshake.
// Define RANDOM_DELAY_EN to add LFSR-driven back-pressure and response stalls.
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LAT    = 1,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  // Handshake: a request is accepted on a rising edge where req and addr_ok
  // are both 1; its response is the data_ok/rdata pair LAT or more cycles
  // later, strictly in acceptance order, one per cycle.

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] LAT_C   = AGE_W'(LAT);

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              hs;
  logic              fire;
  logic              accept_gate;
  logic              head_hold;
  logic              head_wr;
  logic [31:0]       head_data;
  logic [AGE_W-1:0]  head_age;
  logic [CNT_W-1:0]  count;
  logic              unused_bits;

  assign idx = addr[ADDR_W+1:2];

  // Transfer size and the aliased address bits carry no behaviour here.
  assign unused_bits = &{1'b0, size, addr[1:0], addr[31:ADDR_W+2]};

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= LFSR_SEED;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign accept_gate = ~lfsr[0];
  assign head_hold   = lfsr[1];
`else
  assign accept_gate = 1'b1;
  assign head_hold   = 1'b0;
`endif

  assign addr_ok = resetn && (count < DEPTH_C) && accept_gate;
  assign hs      = req && addr_ok;
  assign fire    = (count != '0) && (head_age >= LAT_C) && !head_hold;
  assign data_ok = fire;
  assign rdata   = (fire && !head_wr) ? head_data : 32'h0;

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (hs && wr) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
  end

  resp_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (hs),
    .push_wr   (wr),
    .push_data (mem[idx]),
    .pop       (fire),
    .head_wr   (head_wr),
    .head_data (head_data),
    .head_age  (head_age),
    .count     (count)
  );

endmodule
